// File: rtl/ps2_scancode_decoder_if.sv
// Byte-pop link between the ps2_keyboard FIFO and the scan-code decoder.
// master: FIFO side, drives head byte (data) and non-empty flag (ready).
// slave: decoder side, drives the active-low pop strobe (nextdata_n).
interface ps2_scancode_decoder_if;
    logic [7:0] data;
    logic       ready;
    logic       nextdata_n;

    modport master (output data, output ready, input nextdata_n);
    modport slave  (input data, input ready, output nextdata_n);
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: pops FIFO bytes, tracks E0/F0 prefixes, publishes held key.
// Latency: one byte per 3 cycles (IDLE->POP->DECODE); outputs register one cycle after DECODE.
// Backpressure: never pops while ready is low; the pop strobe lasts exactly one cycle.
// Ports: clk, clrn (sync active-low), bus (slave: data/ready in, nextdata_n out),
//   key_code/key_ext/ascii/key_valid (held key), press/key_release (1-cycle pulses),
//   key_count (presses since reset, wraps modulo 2^COUNT_W).
module ps2_scancode_decoder #(
    parameter int COUNT_W = 8
) (
    input  logic                      clk,
    input  logic                      clrn,
    ps2_scancode_decoder_if.slave     bus,
    output logic [7:0]                key_code,
    output logic                      key_ext,
    output logic [7:0]                ascii,
    output logic                      key_valid,
    output logic                      press,
    output logic                      key_release,
    output logic [COUNT_W-1:0]        key_count
);

    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_r;
    logic       ext_f, brk_f;

    logic pop_start, set_ext, set_brk, code_byte, held_hit, do_press, do_release;

    function automatic logic [7:0] lut(input logic [7:0] c, input logic e);
        logic [7:0] a;
        a = 8'h00;
        if (!e) begin
            case (c)
                8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
                8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
                8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
                8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
                8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
                8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
                8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
                8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
                8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
                8'h3E: a = 8'h38; 8'h46: a = 8'h39;
                8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.ready) state_d = POP;
            POP:     state_d = DECODE;
            DECODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/action decode
    always_comb begin
        pop_start  = (state_q == IDLE) && bus.ready;
        set_ext    = (state_q == DECODE) && (byte_r == 8'hE0);
        set_brk    = (state_q == DECODE) && (byte_r == 8'hF0);
        code_byte  = (state_q == DECODE) && (byte_r != 8'hE0) && (byte_r != 8'hF0);
        // Same code and same E0-ness as the held key.
        held_hit   = key_valid && (byte_r == key_code) && (ext_f == key_ext);
        // A make of the already-held key is typematic repeat and is swallowed.
        do_press   = code_byte && !brk_f && !held_hit;
        do_release = code_byte &&  brk_f &&  held_hit;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!clrn) begin
            bus.nextdata_n <= 1'b1;
            byte_r         <= 8'h00;
            ext_f          <= 1'b0;
            brk_f          <= 1'b0;
            key_code       <= 8'h00;
            key_ext        <= 1'b0;
            ascii          <= 8'h00;
            key_valid      <= 1'b0;
            press          <= 1'b0;
            key_release    <= 1'b0;
            key_count      <= '0;
        end else begin
            bus.nextdata_n <= !pop_start;
            if (pop_start) byte_r <= bus.data;

            if (set_ext) ext_f <= 1'b1;
            if (set_brk) brk_f <= 1'b1;
            if (code_byte) begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end

            press       <= do_press;
            key_release <= do_release;

            if (do_press) begin
                key_code  <= byte_r;
                key_ext   <= ext_f;
                ascii     <= lut(byte_r, ext_f);
                key_valid <= 1'b1;
                key_count <= key_count + COUNT_W'(1);
            end
            // The released key's code/ext/ascii stay visible for the display.
            if (do_release) key_valid <= 1'b0;
        end
    end

endmodule
